fire2_squeeze_ofm_writer: RTL and testbench
===========================================

FIRE2_SQUEEZE_OFM_WRITER -- requirements
Module: fire2_squeeze_ofm_writer

Interface
REQ-001 Parameter WIDTH, default 16: bit width of one feature-map word.
REQ-002 Parameter DSP_NO, default 16: number of parallel squeeze channels delivered per sample.
REQ-003 Parameter WOUT, default 64: output map side; the layer contains WOUT*WOUT pixels.
REQ-004 Parameter AW, default $clog2(WOUT*WOUT*DSP_NO): width of the RAM address.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 sample_in  in  1  one-cycle pulse; ofm_in is valid in the same cycle.
REQ-008 ofm_in  in  WIDTH x [0:DSP_NO-1]  squeeze outputs for one pixel, one word per channel.
REQ-009 ram_we  out  1  feature-map RAM write enable.
REQ-010 ram_addr  out  AW  RAM write address.
REQ-011 ram_wdata  out  WIDTH  RAM write data.
REQ-012 ram_feedback  out  1  busy flag, high while a pixel is being written.
REQ-013 layer_done  out  1  sticky flag, high once all WOUT*WOUT pixels are written.
REQ-014 overflow_err  out  1  sticky flag, high if a sample_in pulse was dropped.

Function
REQ-015 All outputs, as well as the state, pixel counter, channel counter and capture registers, shall be registered.
REQ-016 The block shall implement an FSM with three states, IDLE, WRITE and DONE; the reset state is IDLE.
REQ-017 In IDLE, sample_in=1 shall, on the same edge:
- capture all DSP_NO words of ofm_in into a shadow buffer;
- clear the channel counter to 0;
- move the FSM to WRITE.
REQ-018 Write sequence, for channel counter ch = 0 .. DSP_NO-1 on consecutive cycles:
- ram_we=1 and ram_feedback=1;
- ram_wdata = shadow[ch];
- ram_addr = pixel*DSP_NO + ch (pixel-major layout, address is an unsigned AW-bit value).
REQ-019 Write latency: the first write (ch=0) shall be visible in the cycle after sample_in; ram_feedback shall stay high for exactly DSP_NO cycles.
REQ-020 On the edge that completes ch=DSP_NO-1, the block shall:
- drive ram_we=0 and ram_feedback=0;
- increment the pixel counter;
- return to IDLE, or enter DONE if the pixel just written was WOUT*WOUT-1.
REQ-021 DONE shall be terminal: layer_done=1, ram_we=0 and ram_feedback=0 until reset.
REQ-022 In DONE, sample_in shall be ignored and shall not set overflow_err.
REQ-023 sample_in=1 while in WRITE, including on the final write cycle, shall be dropped; the in-progress pixel shall complete unchanged and overflow_err shall be set to 1 and stay set.
REQ-024 The shadow buffer shall change only on an accepted sample; ofm_in changes during WRITE shall not affect ram_wdata.
REQ-025 The pixel counter shall be $clog2(WOUT*WOUT)+1 bits wide and shall never wrap; the transition to DONE replaces the wrap.
REQ-026 ram_wdata and ram_addr in cycles where ram_we=0 are don't-care and shall not be checked.

Reset
REQ-027 rst=0 shall immediately, without waiting for a clock edge, force:
- FSM to IDLE;
- pixel and channel counters to 0;
- ram_we, ram_feedback, layer_done and overflow_err to 0;
- ram_addr and ram_wdata to 0.
REQ-028 Reset during WRITE shall abort the pixel; after release, the next sample_in shall write to address 0.
REQ-029 The shadow buffer needs no reset.

Verification
REQ-030 Single pixel: ofm_in[k]=16'h0100+k, one sample_in pulse ->
- 16 consecutive cycles with ram_we=1, addr 0..15 and data 16'h0100..16'h010F;
- ram_feedback high for exactly those 16 cycles.
REQ-031 Second pixel: a second pulse 577 cycles later -> addresses 16..31 are written; overflow_err stays 0.
REQ-032 Collision: a pulse on the 5th write cycle and another on the 16th (final) write cycle -> both are dropped, overflow_err=1, the current pixel's data is intact and the next accepted pixel is written at base 16.
REQ-033 Layer end, WOUT=2: 4 pulses ->
- addresses 0..63 are written;
- layer_done=1 from the edge after address 63;
- a 5th pulse causes no write and leaves overflow_err=0.
REQ-034 Reset mid-write: rst low during ch=7 of pixel 3 -> all outputs 0 asynchronously; the next pulse after release writes addresses 0..15.
REQ-035 Data hold: ofm_in is randomised every cycle during WRITE -> ram_wdata always matches the values captured on the accepted pulse.

Source files
------------

// File: rtl/fire2_squeeze_ofm_writer.sv
// Serialises one pixel of DSP_NO squeeze words into the OFM RAM, one word per cycle, pixel-major.
// First write one cycle after sample_in, DSP_NO write cycles; pulses arriving while busy are dropped and flagged.
module fire2_squeeze_ofm_writer #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 16,
  parameter int WOUT   = 64,
  parameter int AW     = $clog2(WOUT*WOUT*DSP_NO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_in,
  input  logic [WIDTH-1:0] ofm_in [0:DSP_NO-1],
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_feedback,
  output logic             layer_done,
  output logic             overflow_err
);
  localparam int NPIX = WOUT*WOUT;
  localparam int PW   = $clog2(NPIX) + 1;
  localparam int CW   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    pixel;
  logic [CW-1:0]    ch;
  logic [CW-1:0]    ch_nxt;
  logic [AW-1:0]    pixel_base;
  logic             accept;
  logic [WIDTH-1:0] shadow [0:DSP_NO-1];

  assign accept     = (state == IDLE) && sample_in;
  assign ch_nxt     = ch + CW'(1);
  assign pixel_base = AW'(pixel) * AW'(DSP_NO);

  // Shadow holds the accepted pixel so ofm_in is free to move during WRITE.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow <= ofm_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pixel        <= '0;
      ch           <= '0;
      ram_we       <= 1'b0;
      ram_feedback <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      layer_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_in) begin
            state        <= WRITE;
            ch           <= '0;
            ram_we       <= 1'b1;
            ram_feedback <= 1'b1;
            ram_addr     <= pixel_base;
            ram_wdata    <= ofm_in[0];
          end
        end
        WRITE: begin
          if (sample_in) begin
            overflow_err <= 1'b1;
          end
          if (ch == CW'(DSP_NO-1)) begin
            ram_we       <= 1'b0;
            ram_feedback <= 1'b0;
            pixel        <= pixel + PW'(1);
            // Last pixel of the layer parks in DONE instead of wrapping the counter.
            if (pixel == PW'(NPIX-1)) begin
              state      <= DONE;
              layer_done <= 1'b1;
            end else begin
              state      <= IDLE;
            end
          end else begin
            ch        <= ch_nxt;
            ram_addr  <= ram_addr + AW'(1);
            ram_wdata <= shadow[ch_nxt];
          end
        end
        DONE: begin
          ram_we       <= 1'b0;
          ram_feedback <= 1'b0;
          layer_done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fire2_squeeze_ofm_writer.sv
// Randomised bench for the OFM writer against a queue-based reference of expected RAM writes.
module tb_fire2_squeeze_ofm_writer;
  localparam int WIDTH = 16;
  localparam int DSP   = 16;
  localparam int WOUT  = 2;
  localparam int NPIX  = WOUT*WOUT;
  localparam int AW    = $clog2(WOUT*WOUT*DSP);

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_in;
  logic [WIDTH-1:0] ofm_in [0:DSP-1];
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_feedback;
  logic             layer_done;
  logic             overflow_err;

  fire2_squeeze_ofm_writer #(.WIDTH(WIDTH), .DSP_NO(DSP), .WOUT(WOUT)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .ofm_in(ofm_in),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_feedback(ram_feedback), .layer_done(layer_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: a pulse at edge n is accepted when n >= free_edge and the layer is not full;
  // an accepted pixel yields DSP consecutive writes starting on that same edge.
  int edge_no;
  int free_edge;
  int pix;
  int done_at;
  bit m_ovf;
  logic [AW+WIDTH-1:0] wq[$];

  logic [3:0]       exp_f, obs_f;
  logic [AW-1:0]    exp_a, obs_a;
  logic [WIDTH-1:0] exp_d, obs_d;

  task automatic model_reset();
    wq.delete();
    free_edge = 0;
    pix       = 0;
    done_at   = 32'h3fff_ffff;
    m_ovf     = 1'b0;
  endtask

  task automatic model_edge(input bit pulse);
    bit we;
    bit done;
    if (pulse) begin
      if (edge_no < free_edge) m_ovf = 1'b1;
      else if (pix < NPIX) begin
        for (int k = 0; k < DSP; k++) wq.push_back({AW'(pix*DSP + k), ofm_in[k]});
        free_edge = edge_no + DSP + 1;
        if (pix == NPIX-1) done_at = edge_no + DSP;
        pix++;
      end
    end
    we = (wq.size() != 0);
    if (we) {exp_a, exp_d} = wq.pop_front();
    done  = (edge_no >= done_at);
    exp_f = {we, we, done, m_ovf};
    edge_no++;
  endtask

  task automatic step(input bit pulse, input bit rnd);
    sample_in = pulse;
    if (rnd) foreach (ofm_in[k]) ofm_in[k] = WIDTH'($urandom);
    @(posedge clk);
    model_edge(pulse);
    @(negedge clk);
    obs_f = {ram_we, ram_feedback, layer_done, overflow_err};
    obs_a = ram_addr;
    obs_d = ram_wdata;
  endtask

  task automatic assert_rst();
    #2 rst = 1'b0;
    sample_in = 1'b0;
    #1;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_feedback, layer_done, overflow_err, ram_addr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_async: got we%b fb%b done%b ovf%b addr%0d data%h, want all 0",
               ram_we, ram_feedback, layer_done, overflow_err, ram_addr, ram_wdata);
    end
    release_rst();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL reset_idle flags cyc %0d: got %b want %b", i, obs_f, exp_f);
      end
    end
  endtask

  task automatic test_single_pixel();
    int fb_cnt;
    fb_cnt = 0;
    for (int k = 0; k < DSP; k++) ofm_in[k] = 16'h0100 + 16'(k);
    for (int i = 0; i < 21; i++) begin
      step(i == 0, 1'b0);
      fb_cnt += int'(obs_f[2]);
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL single flags cyc %0d: got %b want %b", i, obs_f, exp_f);
      end
      if (exp_f[3]) begin
        checks++;
        if ({obs_a, obs_d} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL single write cyc %0d: got %0d/%h want %0d/%h", i, obs_a, obs_d, exp_a, exp_d);
        end
      end
    end
    checks++;
    if (fb_cnt != DSP) begin
      errors++;
      $display("FAIL single fb_cycles: got %0d want %0d", fb_cnt, DSP);
    end
  endtask

  task automatic test_second_pixel();
    for (int i = 21; i < 577 + 20; i++) begin
      step(i == 577, 1'b1);
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL second flags cyc %0d: got %b want %b", i, obs_f, exp_f);
      end
      if (exp_f[3]) begin
        checks++;
        if ({obs_a, obs_d} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL second write cyc %0d: got %0d/%h want %0d/%h", i, obs_a, obs_d, exp_a, exp_d);
        end
      end
    end
  endtask

  task automatic test_collision();
    assert_rst();
    release_rst();
    for (int i = 0; i < 40; i++) begin
      step(i == 0 || i == 5 || i == 16 || i == 17, 1'b1);
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL collision flags cyc %0d: got %b want %b", i, obs_f, exp_f);
      end
      if (exp_f[3]) begin
        checks++;
        if ({obs_a, obs_d} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL collision write cyc %0d: got %0d/%h want %0d/%h", i, obs_a, obs_d, exp_a, exp_d);
        end
      end
    end
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL collision ovf_sticky: got %b want 1", overflow_err);
    end
  endtask

  task automatic test_layer_end();
    bit [63:0] seen;
    int next_pulse;
    int npulse;
    seen = '0;
    next_pulse = 0;
    npulse = 0;
    assert_rst();
    release_rst();
    for (int i = 0; i < 200; i++) begin
      bit p;
      p = (i == next_pulse) && (npulse < 5);
      if (p) begin
        npulse++;
        next_pulse = i + ((npulse == 4) ? 40 : 17 + $urandom_range(0, 6));
      end
      step(p, 1'b1);
      if (obs_f[3]) seen[obs_a] = 1'b1;
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL layer flags cyc %0d: got %b want %b", i, obs_f, exp_f);
      end
      if (exp_f[3]) begin
        checks++;
        if ({obs_a, obs_d} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL layer write cyc %0d: got %0d/%h want %0d/%h", i, obs_a, obs_d, exp_a, exp_d);
        end
      end
    end
    checks++;
    if ({layer_done, overflow_err} !== 2'b10 || seen !== {64{1'b1}}) begin
      errors++;
      $display("FAIL layer end_state: got done%b ovf%b seen%h want done1 ovf0 all addresses",
               layer_done, overflow_err, seen);
    end
  endtask

  task automatic test_reset_mid_write();
    assert_rst();
    release_rst();
    for (int i = 0; i <= 58; i++) begin
      step(i == 0 || i == 17 || i == 34 || i == 40 || i == 51, 1'b1);
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL midrst flags cyc %0d: got %b want %b", i, obs_f, exp_f);
      end
      if (exp_f[3]) begin
        checks++;
        if ({obs_a, obs_d} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL midrst write cyc %0d: got %0d/%h want %0d/%h", i, obs_a, obs_d, exp_a, exp_d);
        end
      end
    end
    checks++;
    if ({ram_we, ram_addr} !== {1'b1, 6'd55}) begin
      errors++;
      $display("FAIL midrst pre_reset: got we%b addr%0d want we1 addr55", ram_we, ram_addr);
    end
    assert_rst();
    checks++;
    if ({ram_we, ram_feedback, layer_done, overflow_err, ram_addr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL midrst async_clear: got we%b fb%b done%b ovf%b addr%0d data%h, want all 0",
               ram_we, ram_feedback, layer_done, overflow_err, ram_addr, ram_wdata);
    end
    release_rst();
    for (int i = 0; i < 20; i++) begin
      step(i == 0, 1'b1);
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL midrst_after flags cyc %0d: got %b want %b", i, obs_f, exp_f);
      end
      if (exp_f[3]) begin
        checks++;
        if ({obs_a, obs_d} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL midrst_after write cyc %0d: got %0d/%h want %0d/%h", i, obs_a, obs_d, exp_a, exp_d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    assert_rst();
    release_rst();
    for (int i = 0; i < 80; i++) begin
      step(i % 17 == 0, 1'b1);
      checks++;
      if (obs_f !== exp_f) begin
        errors++;
        $display("FAIL b2b flags cyc %0d: got %b want %b", i, obs_f, exp_f);
      end
      if (exp_f[3]) begin
        checks++;
        if ({obs_a, obs_d} !== {exp_a, exp_d}) begin
          errors++;
          $display("FAIL b2b write cyc %0d: got %0d/%h want %0d/%h", i, obs_a, obs_d, exp_a, exp_d);
        end
      end
    end
  endtask

  task automatic test_random_traffic();
    for (int r = 0; r < 3; r++) begin
      assert_rst();
      release_rst();
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 5) == 0, 1'b1);
        checks++;
        if (obs_f !== exp_f) begin
          errors++;
          $display("FAIL random flags run %0d cyc %0d: got %b want %b", r, i, obs_f, exp_f);
        end
        if (exp_f[3]) begin
          checks++;
          if ({obs_a, obs_d} !== {exp_a, exp_d}) begin
            errors++;
            $display("FAIL random write run %0d cyc %0d: got %0d/%h want %0d/%h",
                     r, i, obs_a, obs_d, exp_a, exp_d);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_in = 1'b0;
    foreach (ofm_in[k]) ofm_in[k] = '0;
    edge_no = 0;
    model_reset();
    test_reset();
    test_single_pixel();
    test_second_pixel();
    test_collision();
    test_layer_end();
    test_reset_mid_write();
    test_back_to_back();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
